// File: rtl/elite_7seg_display.sv
// elite_7seg_display
//   Multi-digit seven-segment display engine. Holds an NUM_DIGITS-nibble
//   value that is either loaded from the SPI-side word or advanced by a
//   prescaled tick in hex or BCD. Segments are active-low (bit 0 = a,
//   bit 6 = g) and registered.
//
// Ports
//   CLOCK_50              in   system clock, rising edge
//   Reset_7Seg            in   synchronous active-high reset
//   Elite_7Seg_Disp_Word  in   load value, nibble k -> digit k
//   Elite_7Seg_Set_Flag   in   load strobe (priority over a tick)
//   Elite_7Seg_Mode       in   00 static, 01 hex count, 10 BCD count, 11 blank
//   Elite_7Seg_Segs       out  digit k at [7k+6:7k], 1 = segment off
//   Elite_7Seg_Wrap       out  one-cycle pulse when the count rolls over
//
// Build option
//   ELITE_7SEG_LZ_BLANK_EN : when defined, digits above the most significant
//   nonzero digit are blanked (digit 0 always shown).

module elite_7seg_display #(
  parameter int NUM_DIGITS = 6,
  parameter int PRESCALE   = 50000000,
  parameter int PS_W       = 26
) (
  input  logic                    CLOCK_50,
  input  logic                    Reset_7Seg,
  input  logic [4*NUM_DIGITS-1:0] Elite_7Seg_Disp_Word,
  input  logic                    Elite_7Seg_Set_Flag,
  input  logic [1:0]              Elite_7Seg_Mode,
  output logic [7*NUM_DIGITS-1:0] Elite_7Seg_Segs,
  output logic                    Elite_7Seg_Wrap
);

  localparam int VW = 4 * NUM_DIGITS;
  localparam int SW = 7 * NUM_DIGITS;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'b00,
    MODE_HEX    = 2'b01,
    MODE_BCD    = 2'b10,
    MODE_BLANK  = 2'b11
  } mode_e;

  mode_e           w_mode;
  logic            w_tick;
  logic [VW-1:0]   w_val_hex;
  logic            w_hex_wrap;
  logic [VW-1:0]   w_val_bcd;
  logic            w_bcd_wrap;
  logic [SW-1:0]   w_segs_nxt;

  logic [PS_W-1:0] r_ps;
  logic [VW-1:0]   r_val;
  logic            r_wrap;
  logic [SW-1:0]   r_segs;

  assign w_mode = mode_e'(Elite_7Seg_Mode);
  assign w_tick = (r_ps == PS_W'(PRESCALE - 1));

  function automatic logic [6:0] f_decode(input logic [3:0] d);
    case (d)
      4'h0: f_decode = 7'b1000000;
      4'h1: f_decode = 7'b1111001;
      4'h2: f_decode = 7'b0100100;
      4'h3: f_decode = 7'b0110000;
      4'h4: f_decode = 7'b0011001;
      4'h5: f_decode = 7'b0010010;
      4'h6: f_decode = 7'b0000010;
      4'h7: f_decode = 7'b1111000;
      4'h8: f_decode = 7'b0000000;
      4'h9: f_decode = 7'b0010000;
      4'hA: f_decode = 7'b0001000;
      4'hB: f_decode = 7'b0000011;
      4'hC: f_decode = 7'b1000110;
      4'hD: f_decode = 7'b0100001;
      4'hE: f_decode = 7'b0000110;
      default: f_decode = 7'b0001110;
    endcase
  endfunction

  // Hex increment: the extra MSB is the carry out of the top digit.
  assign {w_hex_wrap, w_val_hex} = {1'b0, r_val} + (VW + 1)'(1);

  // BCD ripple: any digit >= 9 (including A-F) that sees a carry clears
  // and passes it on; a surviving carry means the whole value rolled to 0.
  always_comb begin
    logic v_c;
    v_c       = 1'b1;
    w_val_bcd = r_val;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (v_c) begin
        if (r_val[4*k +: 4] >= 4'd9) begin
          w_val_bcd[4*k +: 4] = '0;
        end else begin
          w_val_bcd[4*k +: 4] = r_val[4*k +: 4] + 4'd1;
          v_c                 = 1'b0;
        end
      end
    end
    w_bcd_wrap = v_c;
  end

  always_comb begin
`ifdef ELITE_7SEG_LZ_BLANK_EN
    logic        v_seen;
    int unsigned v_k;
    v_seen     = 1'b0;
    v_k        = 0;
    w_segs_nxt = '1;
    // Scan from the top digit down; a digit shows once any digit at or
    // above it is nonzero, and digit 0 always shows.
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      v_k = NUM_DIGITS - 1 - i;
      if (r_val[4*v_k +: 4] != 4'd0) v_seen = 1'b1;
      if (w_mode != MODE_BLANK && (v_seen || v_k == 0))
        w_segs_nxt[7*v_k +: 7] = f_decode(r_val[4*v_k +: 4]);
    end
`else
    w_segs_nxt = '1;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (w_mode != MODE_BLANK)
        w_segs_nxt[7*k +: 7] = f_decode(r_val[4*k +: 4]);
    end
`endif
  end

  always_ff @(posedge CLOCK_50) begin
    if (Reset_7Seg) begin
      r_ps   <= '0;
      r_val  <= '0;
      r_wrap <= 1'b0;
      r_segs <= '1;
    end else begin
      r_segs <= w_segs_nxt;
      if (Elite_7Seg_Set_Flag) begin
        r_val  <= Elite_7Seg_Disp_Word;
        r_ps   <= '0;
        r_wrap <= 1'b0;
      end else begin
        r_ps   <= w_tick ? '0 : r_ps + PS_W'(1);
        r_wrap <= 1'b0;
        if (w_tick) begin
          case (w_mode)
            MODE_HEX: begin
              r_val  <= w_val_hex;
              r_wrap <= w_hex_wrap;
            end
            MODE_BCD: begin
              r_val  <= w_val_bcd;
              r_wrap <= w_bcd_wrap;
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign Elite_7Seg_Segs = r_segs;
  assign Elite_7Seg_Wrap = r_wrap;

endmodule
